sram_like_responder: RTL and testbench



---
 rtl/sram_like_responder_pkg.sv | 16 +
 rtl/sram_like_responder_if.sv | 25 ++
 rtl/sram_like_resp_fifo.sv | 81 ++++++++
 rtl/sram_like_responder.sv | 91 +++++++++
 tb/tb_sram_like_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared encodings and response-queue entry type for the SRAM-like responder.
package sram_like_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Wide enough for any LATENCY up to 255.
    localparam int unsigned DELAY_W = 8;

    typedef struct packed {
        logic [31:0]        rdata;
        logic [DELAY_W-1:0] delay;
    } resp_entry_t;

endpackage

// File: rtl/sram_like_responder_if.sv
// SRAM-like request/response bus between a core port (master) and a responder (slave).
interface sram_like_responder_if;
    import sram_like_responder_pkg::*;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue; each live entry counts its remaining latency down to zero.
module sram_like_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [31:0] push_rdata_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        head_ready_o,
    output logic [31:0] head_rdata_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    resp_entry_t      entries_q [DEPTH];
    resp_entry_t      entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] offs;

    always_comb begin
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            // Slot distance from the head tells whether the slot is live.
            offs = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offs} < count_q && entries_q[i].delay != '0) begin
                entries_d[i].delay = entries_q[i].delay - 1'b1;
            end
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            entries_d[wr_ptr_q].rdata = push_rdata_i;
            entries_d[wr_ptr_q].delay = DELAY_W'(LATENCY - 1);
            wr_ptr_d                  = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign head_ready_o = !empty_o && (entries_q[rd_ptr_q].delay == '0);
    assign head_rdata_o = entries_q[rd_ptr_q].rdata;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(pop_i && empty_o));
            assert (!(push_i && full_o));
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus slave: word memory plus in-order responses after a minimum latency.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_responder_if.slave  bus,
    input  logic                  stall_addr,
    input  logic                  stall_data
);

    localparam int unsigned WORDS = 1 << ADDR_W;

    if (LATENCY < 1 || LATENCY >= (1 << DELAY_W)) begin : g_bad_latency
        $error("LATENCY out of range");
    end

    logic [31:0]       mem_q [WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic              accept, mem_we, pop;
    logic              full, empty, head_ready;
    logic [31:0]       head_rdata, push_rdata;
    logic              data_ok_q, data_ok_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              unused_sigs;

    assign word_idx    = bus.addr[ADDR_W+1:2];
    assign unused_sigs = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0], empty};

    // Acceptance looks only at the registered count, so a same-cycle retire frees nothing.
    assign bus.addr_ok = resetn && !stall_addr && !full;

    always_comb begin
        accept     = bus.req && bus.addr_ok;
        mem_we     = accept && bus.wr;
        push_rdata = bus.wr ? 32'h0 : mem_q[word_idx];
        pop        = head_ready && !stall_data;
        data_ok_d  = pop;
        rdata_d    = pop ? head_rdata : rdata_q;
    end

    sram_like_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .push_i       (accept),
        .push_rdata_i (push_rdata),
        .pop_i        (pop),
        .full_o       (full),
        .empty_o      (empty),
        .head_ready_o (head_ready),
        .head_rdata_o (head_rdata)
    );

    // Memory is deliberately outside the reset domain so contents survive resetn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (resetn && bus.req && bus.wr) begin
            assert (bus.size != SZ_WORD || bus.wstrb == 4'hF);
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed and random checks of sram_like_responder against a timestamped queue model.
module tb_sram_like_responder;
    import sram_like_responder_pkg::*;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 2;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic clk        = 1'b0;
    logic resetn     = 1'b0;
    logic stall_addr = 1'b0;
    logic stall_data = 1'b0;

    sram_like_responder_if bus ();

    sram_like_responder #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .stall_addr (stall_addr),
        .stall_data (stall_data)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        q[$];
    logic [31:0] ref_mem [int];
    int unsigned edge_n   = 0;
    logic        exp_dok  = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    int          dok_seen = 0;
    int          accepts  = 0;
    logic [31:0] seen_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check addr_ok, advance model at posedge, check response.
    task automatic step(input logic rq, input logic w, input logic [1:0] sz,
                        input logic [3:0] strb, input logic [31:0] a, input logic [31:0] wd,
                        input logic sa, input logic sd, input logic rn,
                        output logic aok_obs, output bit acc);
        logic        exp_aok;
        bit          pop;
        int          word;
        logic [31:0] nv;
        exp_t        e;
        @(negedge clk);
        bus.req = rq; bus.wr = w; bus.size = sz; bus.wstrb = strb;
        bus.addr = a; bus.wdata = wd;
        stall_addr = sa; stall_data = sd; resetn = rn;
        #1;
        exp_aok = rn && !sa && (q.size() < DEPTH);
        aok_obs = bus.addr_ok;
        check("addr_ok", {31'b0, bus.addr_ok}, {31'b0, exp_aok});
        acc = 1'b0;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            q.delete();
            exp_dok   = 1'b0;
            exp_rdata = 32'h0;
        end else begin
            pop     = (q.size() > 0) && (edge_n >= q[0].due) && !sd;
            exp_dok = pop;
            if (pop) begin
                exp_rdata = q[0].data;
                void'(q.pop_front());
            end
            if (rq && exp_aok) begin
                acc = 1'b1;
                accepts++;
                word = int'(a[ADDR_W+1:2]);
                if (w) begin
                    nv = ref_mem[word];
                    for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = wd[8*b +: 8];
                    ref_mem[word] = nv;
                    e.data = 32'h0;
                end else begin
                    e.data = ref_mem[word];
                end
                e.due = edge_n + LATENCY;
                q.push_back(e);
            end
        end
        #1;
        check("data_ok", {31'b0, bus.data_ok}, {31'b0, exp_dok});
        check("rdata", bus.rdata, exp_rdata);
        if (bus.data_ok) begin
            dok_seen++;
            seen_rdata = bus.rdata;
        end
    endtask

    task automatic idle(input logic sd);
        logic o;
        bit   a;
        step(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, sd, 1'b1, o, a);
    endtask

    // Retries a request until accepted, with a bounded cycle budget.
    task automatic op(input logic w, input logic [3:0] strb, input logic [31:0] a,
                      input logic [31:0] wd, input logic sd);
        logic o;
        bit   acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step(1'b1, w, (strb == 4'hF) ? SZ_WORD : SZ_BYTE, strb, a, wd, 1'b0, sd, 1'b1, o, acc);
        end
        check("op_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b0);
    endtask

    initial begin
        logic        o;
        bit          a;
        int          acc_before;
        logic [31:0] ra, rd;
        logic [3:0]  rs;
        logic        rw;

        bus.req = 0; bus.wr = 0; bus.size = 0; bus.wstrb = 0; bus.addr = 0; bus.wdata = 0;
        step(1'b1, 1'b0, SZ_WORD, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, o, a);
        step(1'b0, 1'b0, SZ_WORD, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, o, a);

        for (int w = 0; w < 16; w++) op(1'b1, 4'hF, 32'(w) << 2, $urandom, 1'b0);
        drain();

        // Write then read back one word.
        dok_seen = 0;
        op(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        op(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0);
        drain();
        check("t1_dok_count", 32'(dok_seen), 32'd2);
        check("t1_rdata", seen_rdata, 32'hDEAD_BEEF);

        // Partial byte-lane write.
        op(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0);
        op(1'b1, 4'b0100, 32'h0000_0020, 32'h00AA_0000, 1'b0);
        op(1'b0, 4'hF, 32'h0000_0020, 32'h0, 1'b0);
        drain();
        check("t2_rdata", seen_rdata, 32'h11AA_3344);

        // Fill the queue under data stall, then release.
        dok_seen = 0;
        for (int i = 0; i < 4; i++) op(1'b0, 4'hF, 32'(i) << 2, 32'h0, 1'b1);
        step(1'b1, 1'b0, SZ_WORD, 4'hF, 32'h0000_0014, 32'h0, 1'b0, 1'b1, 1'b1, o, a);
        check("t3_full_addr_ok", {31'b0, o}, 32'd0);
        op(1'b0, 4'hF, 32'h0000_0014, 32'h0, 1'b0);
        drain();
        check("t3_dok_count", 32'(dok_seen), 32'd5);

        // Write followed immediately by a read of the same word.
        op(1'b1, 4'hF, 32'h0000_0018, 32'hCAFE_F00D, 1'b0);
        op(1'b0, 4'hF, 32'h0000_0018, 32'h0, 1'b0);
        drain();
        check("t4_rdata", seen_rdata, 32'hCAFE_F00D);

        // Reset with three reads outstanding.
        for (int i = 0; i < 3; i++) op(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b1);
        step(1'b0, 1'b0, SZ_WORD, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, o, a);
        dok_seen = 0;
        step(1'b0, 1'b0, SZ_WORD, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o, a);
        check("t5_addr_ok_after_reset", {31'b0, o}, 32'd1);
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("t5_no_dok", 32'(dok_seen), 32'd0);
        op(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0);
        drain();
        check("t5_mem_retained", seen_rdata, 32'hDEAD_BEEF);

        // stall_addr toggling with req held high.
        dok_seen   = 0;
        acc_before = accepts;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, SZ_WORD, 4'hF, 32'(i % 16) << 2, 32'h0, 1'(i % 2), 1'b0, 1'b1,
                 o, a);
        end
        drain();
        check("t6_accepts", 32'(accepts - acc_before), 32'd6);
        check("t6_dok_eq_accepts", 32'(dok_seen), 32'(accepts - acc_before));

        // Random traffic with backpressure and occasional resets.
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom);
            ra = $urandom;
            ra[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
            rd = $urandom;
            rs = (rw && $urandom_range(0, 1) == 0) ? 4'($urandom) : 4'hF;
            step(1'($urandom_range(0, 3) != 0), rw, (rs == 4'hF) ? SZ_WORD : SZ_BYTE, rs, ra,
                 rd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 49) != 0, o, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
